// File: rtl/clks_alot_p.sv
// Clock-recovery shared widths and limit bundles.
package clks_alot_p;

  parameter int COUNTER_WIDTH = 16;

  typedef struct packed {
    logic [COUNTER_WIDTH-1:0] minimum_band_minus_one;
    logic [COUNTER_WIDTH-1:0] maximum_band_minus_one;
  } half_rate_limits_s;

endpackage

// File: rtl/common_p.sv
// Shared clock-domain bundle types.
package common_p;

  typedef struct packed {
    logic clk;
    logic rst;
  } clk_dom_s;

endpackage

// File: rtl/edge_rate_meter.sv
// Glitch-filtered edge interval meter feeding the lock-in stage.
// Optional glitch counter: EDGE_RATE_METER_GLITCH_COUNT_EN.
module edge_rate_meter #(
  parameter int SYNC_STAGES   = 2,
  parameter int COUNTER_WIDTH = clks_alot_p::COUNTER_WIDTH
) (
  input  common_p::clk_dom_s             sys_dom_i,
  input  logic                           recovery_en_i,
  input  clks_alot_p::half_rate_limits_s half_rate_limits_i,
  input  logic                           raw_sense_i,
  output logic [COUNTER_WIDTH-1:0]       current_rate_counter_o,
  output logic                           filtered_event_o,
  output logic                           event_level_o,
  output logic                           timeout_o
`ifdef EDGE_RATE_METER_GLITCH_COUNT_EN
  ,
  output logic [7:0]                     glitch_count_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    TRACKING,
    STALLED
  } state_e;

  state_e state;

  logic clk;
  logic rst;

  assign clk = sys_dom_i.clk;
  assign rst = sys_dom_i.rst;

  logic [SYNC_STAGES-1:0]   sync_ff;
  logic                     sync_q;
  logic                     acc_level;
  logic [COUNTER_WIDTH-1:0] cnt;
  logic [COUNTER_WIDTH-1:0] cnt_nxt;
  logic [COUNTER_WIDTH-1:0] min_b;
  logic [COUNTER_WIDTH-1:0] max_b;
  logic                     cand;
  logic                     accept;
  logic                     over;

  assign sync_q = sync_ff[SYNC_STAGES-1];
  assign min_b  =
    COUNTER_WIDTH'(half_rate_limits_i.minimum_band_minus_one);
  assign max_b  =
    COUNTER_WIDTH'(half_rate_limits_i.maximum_band_minus_one);

  assign cand    = sync_q != acc_level;
  assign accept  = cand && (cnt >= min_b);
  assign over    = cnt > max_b;
  assign cnt_nxt = (cnt == '1) ? cnt : cnt + COUNTER_WIDTH'(1);

`ifdef EDGE_RATE_METER_GLITCH_COUNT_EN
  // pend_q: a candidate was seen last cycle but was too early to accept
  logic pend_q;
  logic glitch_hit;

  assign glitch_hit = pend_q && !cand;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      sync_ff                <= '0;
      acc_level              <= 1'b0;
      cnt                    <= '0;
      current_rate_counter_o <= '0;
      filtered_event_o       <= 1'b0;
      event_level_o          <= 1'b0;
      timeout_o              <= 1'b0;
`ifdef EDGE_RATE_METER_GLITCH_COUNT_EN
      pend_q                 <= 1'b0;
      glitch_count_o         <= '0;
`endif
    end else begin
      sync_ff          <= {sync_ff[SYNC_STAGES-2:0], raw_sense_i};
      filtered_event_o <= 1'b0;
      if (!recovery_en_i) begin
        state     <= IDLE;
        cnt       <= '0;
        acc_level <= sync_q;
        timeout_o <= 1'b0;
`ifdef EDGE_RATE_METER_GLITCH_COUNT_EN
        pend_q    <= 1'b0;
`endif
      end else if (state == IDLE) begin
        state     <= ACQUIRE;
        cnt       <= '0;
        acc_level <= sync_q;
`ifdef EDGE_RATE_METER_GLITCH_COUNT_EN
        pend_q         <= 1'b0;
        glitch_count_o <= '0;
`endif
      end else begin
        cnt <= accept ? '0 : cnt_nxt;
        if (accept) begin
          acc_level     <= sync_q;
          event_level_o <= sync_q;
        end
`ifdef EDGE_RATE_METER_GLITCH_COUNT_EN
        pend_q <= cand && !accept;
        if (glitch_hit && (glitch_count_o != 8'hFF)) begin
          glitch_count_o <= glitch_count_o + 8'd1;
        end
`endif
        unique case (state)
          ACQUIRE: begin
            if (accept) begin
              state <= TRACKING;
            end else if (over) begin
              state     <= STALLED;
              timeout_o <= 1'b1;
            end
          end
          TRACKING: begin
            // an over-long interval that ends this cycle just resyncs
            if (accept) begin
              if (!over) begin
                current_rate_counter_o <= cnt;
                filtered_event_o       <= 1'b1;
              end
            end else if (over) begin
              state     <= STALLED;
              timeout_o <= 1'b1;
            end
          end
          STALLED: begin
            if (accept) begin
              state     <= TRACKING;
              timeout_o <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
